io_input_ctrl: RTL and testbench
================================

Name: io_input_ctrl

Overview:
- Controller in front of the memory-mapped input registers of the pipelined computer.
- Synchronises and samples the two 32-bit switch ports.
- Debounces the two mode keys (AND, ADD) into sticky event flags.
- Serves CPU loads on addr[7:2] with one-cycle registered latency. Reading a flag clears it, so the CPU sees each key press exactly once.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a key level is accepted (minimum 1, counter width = clog2(DEBOUNCE_CYCLES+1)).
- DATA_W, 32, width of ports and read data.

Ports:
- io_clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- addr  input  32  CPU load address; only addr[7:2] is decoded.
- rd_en  input  1  one-cycle CPU load strobe for the I/O space.
- in_port0  input  32  raw switch port 0, asynchronous.
- in_port1  input  32  raw switch port 1, asynchronous.
- key_and_raw  input  1  raw AND-mode key, asynchronous, bouncy.
- key_add_raw  input  1  raw ADD-mode key, asynchronous, bouncy.
- io_read_data  output  32  registered load data.
- rd_valid  output  1  high the cycle after an accepted rd_en.
- and_model  output  1  sticky AND-key event flag.
- add_model  output  1  sticky ADD-key event flag.

Behaviour:
- Reset (synchronous, active-high):
  - io_read_data=0, rd_valid=0, and_model=0, add_model=0.
  - Synchronisers, sampled ports, change flags and debounce counters are cleared.
  - Debounced key levels are forced to 0.
  - Reset asserted mid-debounce abandons the count. No press event may be generated in the reset cycle or in the first cycle after it.
- Synchronisation:
  - Every raw input passes through two io_clk flops.
  - in_reg0/in_reg1 take the synchronised value every cycle.
  - Port change to read data: 3 cycles (2 sync flops + sample register).
- Change flags:
  - chg0 sets when the synchronised port0 differs from in_reg0. chg1 is the same for port1.
  - Each clears on a read of its port.
  - Set and clear in the same cycle: set wins.
- Key debounce, per key, in sub-module io_key_debounce. States:
  - IDLE: stable=0. Synced level 1 -> counter=1, go to ARMING.
  - ARMING: level 1 -> counter+1. On reaching DEBOUNCE_CYCLES -> PRESSED, stable=1, emit a one-cycle press pulse. Level 0 -> counter=0, back to IDLE.
  - PRESSED: level 0 -> counter=1, go to RELEASING.
  - RELEASING: level 0 -> counter+1. On reaching DEBOUNCE_CYCLES -> IDLE, stable=0, no pulse. Level 1 -> PRESSED.
  - A held key produces exactly one pulse.
- Sticky flags:
  - A press pulse sets and_model / add_model.
  - An accepted read of 140 / 144 clears the corresponding flag at the same edge that registers the data.
  - Read data returns the pre-clear value.
  - Pulse and clear in the same cycle: the flag stays 1 (event not lost).
- Read decode (rd_en=1, on addr[7:2]):
  - 6'b100000 (128): in_reg0, clears chg0.
  - 6'b100001 (132): in_reg1, clears chg1.
  - 6'b100010 (136): status = {28'b0, chg1, chg0, add_model, and_model}. Status reads have no side effects.
  - 6'b100011 (140): {31'b0, and_model}.
  - 6'b100100 (144): {31'b0, add_model}.
  - Any other value: data 0, rd_valid still 1.
- rd_en=0: io_read_data holds its previous value, rd_valid=0, no side effects.
- Back-to-back reads are accepted every cycle, each with 1-cycle latency.

Decomposition:
- Shared package io_pkg holds:
  - address constants IO_ADDR_PORT0=6'h20, IO_ADDR_PORT1=6'h21, IO_ADDR_STATUS=6'h22, IO_ADDR_AND=6'h23, IO_ADDR_ADD=6'h24;
  - status bit-index constants;
  - the debounce state enum {IDLE, ARMING, PRESSED, RELEASING}.
- Sub-module io_key_debounce (parameter DEBOUNCE_CYCLES; ports io_clk, reset, raw, stable, press_pulse), instantiated twice.

Test Plan:
- Reset then read 140, 144, 136 -> rd_valid=1 one cycle later, data 0, 0, 0.
- in_port0=32'hDEADBEEF at cycle 0 -> read 128 issued at cycle 3 returns 32'hDEADBEEF. Status read before it shows bit2=1; read after the 128 read shows bit2=0.
- key_and_raw pattern 1,0,1,0,1 then held 1 for 10 cycles (DEBOUNCE_CYCLES=4):
  - exactly one press pulse and and_model=1;
  - first read of 140 returns 1, second returns 0;
  - continued holding produces no new event.
- Same-cycle conflict: force the ADD press pulse on the same edge as an accepted read of 144 with add_model=1 -> read returns 1 and add_model remains 1.
- Reset asserted during ARMING (counter=2) -> no pulse. Key held through reset release needs a full 4 fresh cycles (plus sync) before add_model sets.
- Read of addr 8'h9C (sel 6'b100111) -> data 0, rd_valid=1, no flag changes. Reads at cycles n and n+1 return their own data at n+1 and n+2.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped input controller.
package io_pkg;

  localparam int unsigned SEL_W = 6;

  localparam logic [SEL_W-1:0] IO_ADDR_PORT0  = 6'h20;
  localparam logic [SEL_W-1:0] IO_ADDR_PORT1  = 6'h21;
  localparam logic [SEL_W-1:0] IO_ADDR_STATUS = 6'h22;
  localparam logic [SEL_W-1:0] IO_ADDR_AND    = 6'h23;
  localparam logic [SEL_W-1:0] IO_ADDR_ADD    = 6'h24;

  localparam int unsigned ST_AND_BIT  = 0;
  localparam int unsigned ST_ADD_BIT  = 1;
  localparam int unsigned ST_CHG0_BIT = 2;
  localparam int unsigned ST_CHG1_BIT = 3;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    PRESSED,
    RELEASING
  } db_state_e;

endpackage

// File: rtl/io_key_debounce.sv
// Two-flop synchroniser plus debounce FSM for one mode key; emits a single
// press pulse per accepted press.
module io_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic io_clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press_pulse
);
  import io_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            sync1_q, sync2_q;
  db_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            pulse_q, pulse_d;

  always_ff @(posedge io_clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
    end
  end

  // Counter only advances while the level matches the pending transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        stable_d = 1'b0;
        if (sync2_q) begin
          if (CNT_ONE == CNT_MAX) begin
            state_d  = PRESSED;
            stable_d = 1'b1;
            pulse_d  = 1'b1;
            cnt_d    = '0;
          end else begin
            state_d = ARMING;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ARMING: begin
        if (sync2_q) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == CNT_MAX) begin
            state_d  = PRESSED;
            stable_d = 1'b1;
            pulse_d  = 1'b1;
            cnt_d    = '0;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          if (CNT_ONE == CNT_MAX) begin
            state_d  = IDLE;
            stable_d = 1'b0;
            cnt_d    = '0;
          end else begin
            state_d = RELEASING;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RELEASING: begin
        if (!sync2_q) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == CNT_MAX) begin
            state_d  = IDLE;
            stable_d = 1'b0;
            cnt_d    = '0;
          end
        end else begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        stable_d = 1'b0;
      end
    endcase
  end

  assign stable      = stable_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped input register block: synchronised switch ports, change
// flags, debounced sticky key events and a one-cycle registered read port.
module io_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DATA_W          = 32
) (
  input  logic              io_clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] in_port0,
  input  logic [DATA_W-1:0] in_port1,
  input  logic              key_and_raw,
  input  logic              key_add_raw,
  output logic [DATA_W-1:0] io_read_data,
  output logic              rd_valid,
  output logic              and_model,
  output logic              add_model
);
  import io_pkg::*;

  logic [DATA_W-1:0] p0_s1_q, p0_s2_q, in_reg0_q;
  logic [DATA_W-1:0] p1_s1_q, p1_s2_q, in_reg1_q;
  logic              chg0_q, chg0_d, chg1_q, chg1_d;
  logic              and_q, and_d, add_q, add_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic              and_pulse, add_pulse;
  logic              and_level_unused, add_level_unused;
  logic [SEL_W-1:0]  sel_c;
  logic [DATA_W-1:0] status_c;
  logic              unused_addr_bits;

  assign sel_c            = addr[7:2];
  assign unused_addr_bits = ^{addr[31:8], addr[1:0], and_level_unused, add_level_unused};

  io_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_and_db (
    .io_clk      (io_clk),
    .reset       (reset),
    .raw         (key_and_raw),
    .stable      (and_level_unused),
    .press_pulse (and_pulse)
  );

  io_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add_db (
    .io_clk      (io_clk),
    .reset       (reset),
    .raw         (key_add_raw),
    .stable      (add_level_unused),
    .press_pulse (add_pulse)
  );

  always_ff @(posedge io_clk) begin
    if (reset) begin
      p0_s1_q    <= '0;
      p0_s2_q    <= '0;
      in_reg0_q  <= '0;
      p1_s1_q    <= '0;
      p1_s2_q    <= '0;
      in_reg1_q  <= '0;
      chg0_q     <= 1'b0;
      chg1_q     <= 1'b0;
      and_q      <= 1'b0;
      add_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      p0_s1_q    <= in_port0;
      p0_s2_q    <= p0_s1_q;
      in_reg0_q  <= p0_s2_q;
      p1_s1_q    <= in_port1;
      p1_s2_q    <= p1_s1_q;
      in_reg1_q  <= p1_s2_q;
      chg0_q     <= chg0_d;
      chg1_q     <= chg1_d;
      and_q      <= and_d;
      add_q      <= add_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  always_comb begin
    status_c              = '0;
    status_c[ST_AND_BIT]  = and_q;
    status_c[ST_ADD_BIT]  = add_q;
    status_c[ST_CHG0_BIT] = chg0_q;
    status_c[ST_CHG1_BIT] = chg1_q;
  end

  // Read decode; side-effect clears lose to same-cycle set events.
  always_comb begin
    rd_data_d = rd_data_q;
    chg0_d    = chg0_q;
    chg1_d    = chg1_q;
    and_d     = and_q;
    add_d     = add_q;
    if (rd_en) begin
      case (sel_c)
        IO_ADDR_PORT0: begin
          rd_data_d = in_reg0_q;
          chg0_d    = 1'b0;
        end
        IO_ADDR_PORT1: begin
          rd_data_d = in_reg1_q;
          chg1_d    = 1'b0;
        end
        IO_ADDR_STATUS: rd_data_d = status_c;
        IO_ADDR_AND: begin
          rd_data_d = DATA_W'(and_q);
          and_d     = 1'b0;
        end
        IO_ADDR_ADD: begin
          rd_data_d = DATA_W'(add_q);
          add_d     = 1'b0;
        end
        default: rd_data_d = '0;
      endcase
    end
    if (p0_s2_q != in_reg0_q) chg0_d = 1'b1;
    if (p1_s2_q != in_reg1_q) chg1_d = 1'b1;
    if (and_pulse) and_d = 1'b1;
    if (add_pulse) add_d = 1'b1;
  end

  assign io_read_data = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign and_model    = and_q;
  assign add_model    = add_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed bench for io_input_ctrl: inputs change at negedge, outputs are
// checked at the following negedge.
module tb_io_input_ctrl;

  logic        io_clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        rd_en;
  logic [31:0] in_port0, in_port1;
  logic        key_and_raw, key_add_raw;
  logic [31:0] io_read_data;
  logic        rd_valid, and_model, add_model;

  int checks = 0;
  int errors = 0;
  int and_rises = 0;
  logic and_prev = 1'b0;

  io_input_ctrl #(.DEBOUNCE_CYCLES(4), .DATA_W(32)) u_dut (
    .io_clk       (io_clk),
    .reset        (reset),
    .addr         (addr),
    .rd_en        (rd_en),
    .in_port0     (in_port0),
    .in_port1     (in_port1),
    .key_and_raw  (key_and_raw),
    .key_add_raw  (key_add_raw),
    .io_read_data (io_read_data),
    .rd_valid     (rd_valid),
    .and_model    (and_model),
    .add_model    (add_model)
  );

  always #5 io_clk = ~io_clk;

  always @(negedge io_clk) begin
    if (and_model && !and_prev) and_rises++;
    and_prev = and_model;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge io_clk);
  endtask

  // One-cycle load strobe; on return the registered response is visible.
  task automatic rd(input logic [7:0] a);
    addr  = {24'h0, a};
    rd_en = 1'b1;
    @(negedge io_clk);
    rd_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    rd(a);
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, io_read_data, exp);
  endtask

  bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1; addr = '0; rd_en = 1'b0;
    in_port0 = '0; in_port1 = '0; key_and_raw = 1'b0; key_add_raw = 1'b0;
    cyc(2);
    check("rst_data", io_read_data, 32'h0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_flags", {30'h0, add_model, and_model}, 32'h0);
    reset = 1'b0;

    rd_chk("r140", 8'h8C, 32'h0);
    rd_chk("r144", 8'h90, 32'h0);
    rd_chk("r136", 8'h88, 32'h0);
    cyc(1);
    check("idle_valid", 32'(rd_valid), 32'd0);

    // Port0 change: sample register updates on the third edge.
    in_port0 = 32'hDEADBEEF;
    cyc(2);
    rd_chk("p0_early", 8'h80, 32'h0);
    rd_chk("st_chg0", 8'h88, 32'h4);
    rd_chk("p0_read", 8'h80, 32'hDEADBEEF);
    rd_chk("st_clr0", 8'h88, 32'h0);

    in_port1 = 32'h12345678;
    cyc(4);
    rd_chk("st_chg1", 8'h88, 32'h8);

    rd_chk("bad_addr", 8'h9C, 32'h0);
    rd_chk("st_after_bad", 8'h88, 32'h8);

    // Back-to-back loads, then an idle cycle that must hold the data.
    addr = 32'h80; rd_en = 1'b1;
    cyc(1);
    check("b2b0_valid", 32'(rd_valid), 32'd1);
    check("b2b0_data", io_read_data, 32'hDEADBEEF);
    addr = 32'h84;
    cyc(1);
    check("b2b1_valid", 32'(rd_valid), 32'd1);
    check("b2b1_data", io_read_data, 32'h12345678);
    rd_en = 1'b0;
    cyc(1);
    check("hold_valid", 32'(rd_valid), 32'd0);
    check("hold_data", io_read_data, 32'h12345678);
    rd_chk("st_clr1", 8'h88, 32'h0);

    // Bouncy AND key, then held.
    for (int i = 0; i < 4; i++) begin
      key_and_raw = pat[i];
      cyc(1);
    end
    key_and_raw = 1'b1;
    cyc(6);
    check("and_not_yet", 32'(and_model), 32'd0);
    cyc(1);
    check("and_set", 32'(and_model), 32'd1);
    cyc(3);
    check("and_one_rise", 32'(and_rises), 32'd1);
    rd_chk("and_rd1", 8'h8C, 32'h1);
    check("and_cleared", 32'(and_model), 32'd0);
    rd_chk("and_rd2", 8'h8C, 32'h0);
    cyc(5);
    check("and_held_norise", 32'(and_rises), 32'd1);
    check("and_held_flag", 32'(and_model), 32'd0);
    key_and_raw = 1'b0;

    // ADD press, release, repress timed so its pulse meets a clear.
    key_add_raw = 1'b1;
    cyc(8);
    check("add_set", 32'(add_model), 32'd1);
    rd_chk("st_add", 8'h88, 32'h2);
    key_add_raw = 1'b0;
    cyc(8);
    key_add_raw = 1'b1;
    cyc(6);
    rd_chk("add_conflict", 8'h90, 32'h1);
    check("add_kept", 32'(add_model), 32'd1);
    rd_chk("add_rd2", 8'h90, 32'h1);
    check("add_cleared", 32'(add_model), 32'd0);

    // Reset in ARMING with count 2 abandons the press.
    key_add_raw = 1'b0;
    cyc(8);
    rd_chk("pre_rst_p0", 8'h80, 32'hDEADBEEF);
    key_add_raw = 1'b1;
    cyc(4);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_data", io_read_data, 32'h0);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_add", 32'(add_model), 32'd0);
    reset = 1'b0;
    cyc(6);
    check("post_rst_noadd", 32'(add_model), 32'd0);
    cyc(1);
    check("post_rst_add", 32'(add_model), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
